// File: rtl/aibcr3_io_seq_pkg.sv
// Shared types and constants for the AIB IO bring-up/power-down sequencer.
package aibcr3_io_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WEAK     = 3'd1,
        S_PADREL   = 3'd2,
        S_RX_EN    = 3'd3,
        S_TX_EN    = 3'd4,
        S_CORE_REL = 3'd5,
        S_LPBK     = 3'd6,
        S_READY    = 3'd7
    } state_t;

    // Fibonacci LFSR x^7 + x^6 + 1: taps on bits 6 and 5, shifting left.
    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam logic [6:0] LFSR_TAPS = 7'h60;

    localparam logic [2:0] RXEN_OFF_DEF = 3'b010;

    typedef struct packed {
        logic       padrstb;
        logic       rstb;
        logic [2:0] rxen;
        logic       tx_en;
        logic [1:0] pdrv;
        logic [1:0] ndrv;
        logic       lpbk_en;
        logic       weakpu;
        logic       weakpd;
        logic       rdy;
    } ctl_t;

    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic ctl_t ctl_idle(input logic [2:0] rxen_off);
        ctl_t c;
        c        = '0;
        c.rxen   = rxen_off;
        c.weakpu = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/aibcr3_io_seq_lpbk.sv
// Loopback self-test engine: LFSR pattern generator, expected-data delay line,
// comparator and saturating mismatch counter.
module aibcr3_io_seq_lpbk
    import aibcr3_io_seq_pkg::*;
#(
    parameter int LPBK_LEN = 64,
    parameter int LPBK_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       start,
    input  logic       en,
    input  logic [1:0] odat,
    output logic [1:0] idat,
    output logic       done,
    output logic       pass,
    output logic [7:0] errcnt
);

    localparam int CW = $clog2(LPBK_LEN);

    logic [6:0]    lfsr;
    logic [6:0]    lfsr_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    exp_line [LPBK_LAT];
    logic          mismatch;

    assign lfsr_nxt = lfsr_step(lfsr);
    // The delay line is only meaningful once LPBK_LAT patterns have been launched.
    assign mismatch = en && (cnt >= CW'(LPBK_LAT)) && (odat != exp_line[LPBK_LAT-1]);
    assign done     = en && (cnt == CW'(LPBK_LEN - 1));
    assign pass     = (errcnt == 8'd0) && !mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr   <= LFSR_SEED;
            idat   <= 2'b00;
            cnt    <= '0;
            errcnt <= 8'd0;
            for (int i = 0; i < LPBK_LAT; i++) exp_line[i] <= 2'b00;
        end else begin
            if (clr)
                errcnt <= 8'd0;
            else if (mismatch && errcnt != 8'hFF)
                errcnt <= errcnt + 8'd1;

            if (start) begin
                lfsr <= LFSR_SEED;
                idat <= LFSR_SEED[1:0];
                cnt  <= '0;
            end else if (en && !done) begin
                lfsr <= lfsr_nxt;
                idat <= lfsr_nxt[1:0];
                cnt  <= cnt + 1'b1;
            end else begin
                idat <= 2'b00;
            end

            exp_line[0] <= idat;
            for (int i = 1; i < LPBK_LAT; i++) exp_line[i] <= exp_line[i-1];
        end
    end

endmodule

// File: rtl/aibcr3_io_seq.sv
// Per-IO sequencer: walks one AIB IO buffer through weak-pull, pad release, rx/tx
// enable and core release, with an optional loopback self-test before READY.
module aibcr3_io_seq
    import aibcr3_io_seq_pkg::*;
#(
    parameter int         WAIT_CYC = 16,
    parameter int         LPBK_LEN = 64,
    parameter int         LPBK_LAT = 2,
    parameter logic [2:0] RXEN_OFF = RXEN_OFF_DEF
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       istart,
    input  logic       ipwrdn,
    input  logic       icfg_tx,
    input  logic [2:0] icfg_rxen,
    input  logic [1:0] icfg_pdrv,
    input  logic [1:0] icfg_ndrv,
    input  logic       icfg_lpbk,
    input  logic       iodat0,
    input  logic       iodat1,
    output logic       opadrstb,
    output logic       orstb,
    output logic [2:0] orxen,
    output logic       otx_en,
    output logic [1:0] opdrv,
    output logic [1:0] opndrv,
    output logic       olpbk_en,
    output logic       oidat0,
    output logic       oidat1,
    output logic       oweakpu,
    output logic       oweakpd,
    output logic       ordy,
    output logic       ofail,
    output logic [7:0] oerrcnt,
    output logic [2:0] ostate
);

    localparam int             PCW    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [PCW-1:0] RELOAD = PCW'(WAIT_CYC - 1);

    state_t         state;
    logic [PCW-1:0] phase_cnt;
    ctl_t           ctl;
    logic           fail;
    logic [1:0]     rst_sync;
    logic [1:0]     lpbk_dat;
    logic           go, phase_done;
    logic           lpbk_start, lpbk_en, lpbk_clr, lpbk_done, lpbk_pass;

    // NOTE: reset asserts asynchronously but releases through two flops, so the FSM
    // cannot leave IDLE on an edge that races the irst deassertion.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign go         = istart && !ipwrdn && rst_sync[1];
    assign phase_done = (phase_cnt == '0);
    assign lpbk_start = (state == S_CORE_REL) && icfg_lpbk && !ipwrdn;
    assign lpbk_en    = (state == S_LPBK) && !ipwrdn;
    assign lpbk_clr   = (state == S_IDLE) && go;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state     <= S_IDLE;
            phase_cnt <= RELOAD;
            ctl       <= ctl_idle(RXEN_OFF);
            fail      <= 1'b0;
        end else if (state != S_IDLE && ipwrdn) begin
            // Power-down wins over every other transition; the fail status survives.
            state <= S_IDLE;
            ctl   <= ctl_idle(RXEN_OFF);
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    state     <= S_WEAK;
                    phase_cnt <= RELOAD;
                    fail      <= 1'b0;
                end
                S_WEAK: if (phase_done) begin
                    state       <= S_PADREL;
                    phase_cnt   <= RELOAD;
                    ctl.padrstb <= 1'b1;
                end else phase_cnt <= phase_cnt - 1'b1;
                S_PADREL: if (phase_done) begin
                    state     <= S_RX_EN;
                    phase_cnt <= RELOAD;
                    ctl.rxen  <= icfg_rxen;
                end else phase_cnt <= phase_cnt - 1'b1;
                S_RX_EN: if (phase_done) begin
                    phase_cnt <= RELOAD;
                    if (icfg_tx) begin
                        state      <= S_TX_EN;
                        ctl.tx_en  <= 1'b1;
                        ctl.pdrv   <= icfg_pdrv;
                        ctl.ndrv   <= icfg_ndrv;
                        ctl.weakpu <= 1'b0;
                    end else begin
                        state    <= S_CORE_REL;
                        ctl.rstb <= 1'b1;
                    end
                end else phase_cnt <= phase_cnt - 1'b1;
                S_TX_EN: if (phase_done) begin
                    state    <= S_CORE_REL;
                    ctl.rstb <= 1'b1;
                end else phase_cnt <= phase_cnt - 1'b1;
                S_CORE_REL: if (icfg_lpbk) begin
                    state       <= S_LPBK;
                    ctl.lpbk_en <= 1'b1;
                end else begin
                    state   <= S_READY;
                    ctl.rdy <= 1'b1;
                end
                S_LPBK: if (lpbk_done) begin
                    if (lpbk_pass) begin
                        state       <= S_READY;
                        ctl.lpbk_en <= 1'b0;
                        ctl.rdy     <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        ctl   <= ctl_idle(RXEN_OFF);
                        fail  <= 1'b1;
                    end
                end
                S_READY: ;
            endcase
        end
    end

    aibcr3_io_seq_lpbk #(
        .LPBK_LEN (LPBK_LEN),
        .LPBK_LAT (LPBK_LAT)
    ) u_lpbk (
        .clk    (iclk),
        .rst    (irst),
        .clr    (lpbk_clr),
        .start  (lpbk_start),
        .en     (lpbk_en),
        .odat   ({iodat1, iodat0}),
        .idat   (lpbk_dat),
        .done   (lpbk_done),
        .pass   (lpbk_pass),
        .errcnt (oerrcnt)
    );

    assign opadrstb = ctl.padrstb;
    assign orstb    = ctl.rstb;
    assign orxen    = ctl.rxen;
    assign otx_en   = ctl.tx_en;
    assign opdrv    = ctl.pdrv;
    assign opndrv   = ctl.ndrv;
    assign olpbk_en = ctl.lpbk_en;
    assign oweakpu  = ctl.weakpu;
    assign oweakpd  = ctl.weakpd;
    assign ordy     = ctl.rdy;
    assign ofail    = fail;
    assign oidat0   = lpbk_dat[0];
    assign oidat1   = lpbk_dat[1];
    assign ostate   = state;

endmodule

// File: tb/tb_aibcr3_io_seq.sv
// Self-checking bench for aibcr3_io_seq: timed bring-up, loopback pass/fail,
// power-down priority and asynchronous reset with synchronised release.
module tb_aibcr3_io_seq;

    localparam int WAIT = 16;
    localparam int LEN  = 64;
    localparam int LAT  = 2;

    localparam logic [18:0] IDLE_VEC = {3'd0, 1'b0, 1'b0, 3'b010, 1'b0, 2'd0, 2'd0,
                                        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic       iclk, irst, istart, ipwrdn, icfg_tx, icfg_lpbk, iodat0, iodat1;
    logic [2:0] icfg_rxen;
    logic [1:0] icfg_pdrv, icfg_ndrv;
    logic       opadrstb, orstb, otx_en, olpbk_en, oidat0, oidat1;
    logic       oweakpu, oweakpd, ordy, ofail;
    logic [2:0] orxen, ostate;
    logic [1:0] opdrv, opndrv;
    logic [7:0] oerrcnt;

    int total = 0;
    int bad   = 0;

    // Results of the last run_seq call.
    int t_pad, t_tx, t_rdy, t_idle, n_lpbk, pat_err;

    // Reference pattern: one entry per loopback cycle, from the polynomial.
    logic [6:0] pat [LEN];
    bit stuck0 = 1'b0;

    aibcr3_io_seq #(
        .WAIT_CYC (WAIT),
        .LPBK_LEN (LEN),
        .LPBK_LAT (LAT),
        .RXEN_OFF (3'b010)
    ) dut (
        .iclk      (iclk),
        .irst      (irst),
        .istart    (istart),
        .ipwrdn    (ipwrdn),
        .icfg_tx   (icfg_tx),
        .icfg_rxen (icfg_rxen),
        .icfg_pdrv (icfg_pdrv),
        .icfg_ndrv (icfg_ndrv),
        .icfg_lpbk (icfg_lpbk),
        .iodat0    (iodat0),
        .iodat1    (iodat1),
        .opadrstb  (opadrstb),
        .orstb     (orstb),
        .orxen     (orxen),
        .otx_en    (otx_en),
        .opdrv     (opdrv),
        .opndrv    (opndrv),
        .olpbk_en  (olpbk_en),
        .oidat0    (oidat0),
        .oidat1    (oidat1),
        .oweakpu   (oweakpu),
        .oweakpd   (oweakpd),
        .ordy      (ordy),
        .ofail     (ofail),
        .oerrcnt   (oerrcnt),
        .ostate    (ostate)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    // IO slice model: odat returns idat two cycles later; bit 0 can be stuck low.
    initial begin : slice_model
        logic [1:0] h0, h1, h2;
        h0 = 2'b00; h1 = 2'b00; h2 = 2'b00;
        iodat0 = 1'b0; iodat1 = 1'b0;
        forever begin
            @(posedge iclk);
            #1;
            h2 = h1; h1 = h0; h0 = {oidat1, oidat0};
            iodat0 = stuck0 ? 1'b0 : h2[0];
            iodat1 = h2[1];
        end
    end

    function automatic logic [18:0] out_vec();
        return {ostate, opadrstb, orstb, orxen, otx_en, opdrv, opndrv,
                olpbk_en, oidat0, oidat1, oweakpu, oweakpd, ordy};
    endfunction

    function automatic logic [6:0] poly_next(input logic [6:0] v);
        logic fb;
        fb = ((v >> 6) & 7'd1) != ((v >> 5) & 7'd1);
        return ((v << 1) & 7'h7E) | {6'd0, fb};
    endfunction

    // Raise istart on the current negedge and watch max_cyc edges; cycle c means
    // "observed after the c-th clock edge counting the istart sample as edge 1".
    task automatic run_seq(input int max_cyc, input bit hold);
        t_pad = -1; t_tx = -1; t_rdy = -1; t_idle = -1; n_lpbk = 0; pat_err = 0;
        istart = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge iclk);
            if (c == 1 && !hold) istart = 1'b0;
            if (opadrstb && t_pad < 0) t_pad = c;
            if (otx_en && t_tx < 0) t_tx = c;
            if (ordy && t_rdy < 0) t_rdy = c;
            if (ostate == 3'd0 && t_idle < 0) t_idle = c;
            if (ostate == 3'd6) begin
                if (n_lpbk < LEN && {oidat1, oidat0} !== pat[n_lpbk][1:0]) pat_err++;
                n_lpbk++;
            end
        end
    endtask

    task automatic power_down();
        ipwrdn = 1'b1;
        @(negedge iclk);
        ipwrdn = 1'b0;
        @(negedge iclk);
    endtask

    task automatic test_reset();
        irst = 1'b1;
        repeat (3) @(negedge iclk);
        total++;
        if (out_vec() !== IDLE_VEC) begin
            bad++; $display("FAIL reset_outputs: got %h want %h", out_vec(), IDLE_VEC);
        end
        total++;
        if ({ofail, oerrcnt} !== 9'd0) begin
            bad++; $display("FAIL reset_status: got %h want 0", {ofail, oerrcnt});
        end
        irst = 1'b0;
        repeat (3) @(negedge iclk);
        total++;
        if (ostate !== 3'd0) begin
            bad++; $display("FAIL idle_after_release: got %0d want 0", ostate);
        end
    endtask

    task automatic test_nominal();
        logic [18:0] want;
        for (int it = 0; it < 3; it++) begin
            icfg_tx = 1'b1; icfg_lpbk = 1'b0;
            icfg_rxen = 3'($urandom_range(0, 7));
            icfg_pdrv = 2'($urandom_range(0, 3));
            icfg_ndrv = 2'($urandom_range(0, 3));
            run_seq(1 + 4 * WAIT + 1 + 4, 1'b0);
            total++;
            if (t_pad != 1 + WAIT) begin
                bad++; $display("FAIL nominal_padrstb_cycle: got %0d want %0d", t_pad, 1 + WAIT);
            end
            total++;
            if (t_tx != 1 + 3 * WAIT) begin
                bad++; $display("FAIL nominal_tx_en_cycle: got %0d want %0d", t_tx, 1 + 3 * WAIT);
            end
            total++;
            if (t_rdy != 1 + 4 * WAIT + 1) begin
                bad++; $display("FAIL nominal_ready_cycle: got %0d want %0d", t_rdy, 1 + 4 * WAIT + 1);
            end
            want = {3'd7, 1'b1, 1'b1, icfg_rxen, 1'b1, icfg_pdrv, icfg_ndrv,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            total++;
            if (out_vec() !== want) begin
                bad++; $display("FAIL nominal_ready_outputs: got %h want %h", out_vec(), want);
            end
            // Power-down from READY returns everything to reset values next cycle.
            ipwrdn = 1'b1;
            @(negedge iclk);
            ipwrdn = 1'b0;
            total++;
            if (out_vec() !== IDLE_VEC) begin
                bad++; $display("FAIL pwrdn_ready: got %h want %h", out_vec(), IDLE_VEC);
            end
            @(negedge iclk);
        end
    endtask

    task automatic test_no_tx();
        logic [18:0] want;
        icfg_tx = 1'b0; icfg_lpbk = 1'b0;
        icfg_rxen = 3'($urandom_range(0, 7));
        icfg_pdrv = 2'b11; icfg_ndrv = 2'b11;
        run_seq(1 + 3 * WAIT + 1 + 4, 1'b0);
        total++;
        if (t_rdy != 1 + 3 * WAIT + 1) begin
            bad++; $display("FAIL no_tx_ready_cycle: got %0d want %0d", t_rdy, 1 + 3 * WAIT + 1);
        end
        want = {3'd7, 1'b1, 1'b1, icfg_rxen, 1'b0, 2'd0, 2'd0,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        total++;
        if (out_vec() !== want || t_tx != -1) begin
            bad++; $display("FAIL no_tx_outputs: got %h tx_cycle %0d want %h tx_cycle -1",
                            out_vec(), t_tx, want);
        end
        power_down();
    endtask

    task automatic test_lpbk_pass();
        icfg_tx = 1'b1; icfg_lpbk = 1'b1; stuck0 = 1'b0;
        icfg_rxen = 3'b101; icfg_pdrv = 2'b10; icfg_ndrv = 2'b01;
        run_seq(1 + 4 * WAIT + 1 + LEN + 4, 1'b0);
        total++;
        if (t_rdy != 1 + 4 * WAIT + 1 + LEN) begin
            bad++; $display("FAIL lpbk_pass_ready_cycle: got %0d want %0d", t_rdy, 1 + 4 * WAIT + 1 + LEN);
        end
        total++;
        if (n_lpbk != LEN || pat_err != 0) begin
            bad++; $display("FAIL lpbk_pattern: got %0d cycles %0d bad bits want %0d cycles 0 bad",
                            n_lpbk, pat_err, LEN);
        end
        total++;
        if ({ofail, oerrcnt, olpbk_en, ordy} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL lpbk_pass_status: got fail=%0b err=%0d lpbk=%0b rdy=%0b want 0/0/0/1",
                            ofail, oerrcnt, olpbk_en, ordy);
        end
        power_down();
    endtask

    task automatic test_lpbk_fail();
        int want_err;
        want_err = 0;
        for (int k = LAT; k < LEN; k++)
            if (pat[k - LAT][0]) want_err++;
        if (want_err > 255) want_err = 255;
        icfg_tx = 1'b1; icfg_lpbk = 1'b1; stuck0 = 1'b1;
        run_seq(1 + 4 * WAIT + 1 + LEN + 5, 1'b0);
        stuck0 = 1'b0;
        total++;
        if (ofail !== 1'b1 || oerrcnt !== 8'(want_err)) begin
            bad++; $display("FAIL lpbk_fail_status: got fail=%0b err=%0d want fail=1 err=%0d",
                            ofail, oerrcnt, want_err);
        end
        total++;
        if (t_rdy != -1 || t_idle != 1 + 4 * WAIT + 1 + LEN) begin
            bad++; $display("FAIL lpbk_fail_return: got rdy_cycle %0d idle_cycle %0d want -1 %0d",
                            t_rdy, t_idle, 1 + 4 * WAIT + 1 + LEN);
        end
        total++;
        if (out_vec() !== IDLE_VEC) begin
            bad++; $display("FAIL lpbk_fail_outputs: got %h want %h", out_vec(), IDLE_VEC);
        end
    endtask

    task automatic test_pwrdn_tx_en();
        icfg_tx = 1'b1; icfg_lpbk = 1'b0;
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        total++;
        if ({ostate, ofail, oerrcnt} !== {3'd1, 1'b0, 8'd0}) begin
            bad++; $display("FAIL restart_clears_fail: got state=%0d fail=%0b err=%0d want 1/0/0",
                            ostate, ofail, oerrcnt);
        end
        repeat (3 * WAIT + WAIT - 1) @(negedge iclk);
        total++;
        if (ostate !== 3'd4) begin
            bad++; $display("FAIL pwrdn_tx_en_setup: got %0d want 4", ostate);
        end
        ipwrdn = 1'b1;
        @(negedge iclk);
        ipwrdn = 1'b0;
        total++;
        if (out_vec() !== IDLE_VEC || {ofail, oerrcnt} !== 9'd0) begin
            bad++; $display("FAIL pwrdn_tx_en: got %h st %h want %h st 0",
                            out_vec(), {ofail, oerrcnt}, IDLE_VEC);
        end
        @(negedge iclk);
    endtask

    task automatic test_async_reset();
        icfg_tx = 1'b1; icfg_lpbk = 1'b1; stuck0 = 1'b0;
        istart = 1'b1;
        repeat (1 + 4 * WAIT + 1 + 12) @(negedge iclk);
        total++;
        if (ostate !== 3'd6) begin
            bad++; $display("FAIL async_setup_lpbk: got %0d want 6", ostate);
        end
        #2 irst = 1'b1;
        #1;
        total++;
        if (out_vec() !== IDLE_VEC || {ofail, oerrcnt} !== 9'd0) begin
            bad++; $display("FAIL async_reset_immediate: got %h want %h", out_vec(), IDLE_VEC);
        end
        @(negedge iclk);
        irst = 1'b0;
        @(negedge iclk);
        @(negedge iclk);
        total++;
        if (ostate !== 3'd0) begin
            bad++; $display("FAIL async_sync_hold: got %0d want 0", ostate);
        end
        @(negedge iclk);
        total++;
        if (ostate !== 3'd1) begin
            bad++; $display("FAIL async_restart_weak: got %0d want 1", ostate);
        end
        istart = 1'b0;
        power_down();
    endtask

    initial begin
        istart = 1'b0; ipwrdn = 1'b0; icfg_tx = 1'b0; icfg_lpbk = 1'b0;
        icfg_rxen = 3'd0; icfg_pdrv = 2'd0; icfg_ndrv = 2'd0;
        irst = 1'b1;
        pat[0] = 7'h7F;
        for (int j = 1; j < LEN; j++) pat[j] = poly_next(pat[j-1]);

        test_reset();
        test_nominal();
        test_no_tx();
        test_lpbk_pass();
        test_lpbk_fail();
        test_pwrdn_tx_en();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
